// File: rtl/ro_ex_wb_dest_pipe_pkg.sv
// Shared types for the RO->EX->WB destination-tracking pipeline.
// Holds the destination bundle layout and the per-stage occupancy states.
package ro_ex_wb_dest_pipe_pkg;

  localparam int REG_IDX_W = 3;
  localparam logic [REG_IDX_W-1:0] EAX = 3'h0;
  localparam logic [REG_IDX_W-1:0] ECX = 3'h1;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dreg1;
    logic [REG_IDX_W-1:0] dreg2;
    logic [REG_IDX_W-1:0] dreg3;
    logic                 ld_reg1;
    logic                 ld_reg2;
    logic                 ld_reg3;
    logic [REG_IDX_W-1:0] dmm;
    logic                 ld_mm;
    logic [REG_IDX_W-1:0] dseg;
    logic                 ld_seg;
  } dest_bundle_t;

  typedef enum logic {
    ST_EMPTY    = 1'b0,
    ST_OCCUPIED = 1'b1
  } stage_state_e;

  // Masks every load-enable of a bundle with the stage valid; indices pass through.
  function automatic dest_bundle_t qualify(input dest_bundle_t b, input logic valid);
    dest_bundle_t q;
    q         = b;
    q.ld_reg1 = b.ld_reg1 & valid;
    q.ld_reg2 = b.ld_reg2 & valid;
    q.ld_reg3 = b.ld_reg3 & valid;
    q.ld_mm   = b.ld_mm & valid;
    q.ld_seg  = b.ld_seg & valid;
    return q;
  endfunction

endpackage

// File: rtl/ro_ex_wb_dest_pipe_stage.sv
// One pipeline stage: occupancy state plus the destination bundle.
// flush empties the stage and wins over load; fields hold during flush.
module ro_ex_wb_dest_pipe_stage
  import ro_ex_wb_dest_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         valid_in,
  input  dest_bundle_t bundle_in,
  output stage_state_e state,
  output dest_bundle_t bundle_q
);

  stage_state_e state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else if (load) begin
      state_next = valid_in ? ST_OCCUPIED : ST_EMPTY;
    end
  end

  // Fields follow the load enable irrespective of valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q <= '0;
    end else if (load && !flush) begin
      bundle_q <= bundle_in;
    end
  end

endmodule

// File: rtl/ro_ex_wb_dest_pipe.sv
// EX/WB destination pipeline feeding the RO dependency check, with
// in-flight count and a saturating dependency-stall counter.
module ro_ex_wb_dest_pipe
  import ro_ex_wb_dest_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_ex,
  input  logic             V_ex,
  input  logic [2:0]       ro_dreg1,
  input  logic [2:0]       ro_dreg2,
  input  logic [2:0]       ro_dreg3,
  input  logic             v_ro_ld_reg1,
  input  logic             v_ro_ld_reg2,
  input  logic             v_ro_ld_reg3,
  input  logic [2:0]       ro_dmm,
  input  logic             v_ro_ld_mm,
  input  logic [2:0]       ro_dseg,
  input  logic             v_ro_ld_seg,
  input  logic             ex_dep_stall,
  input  logic             wb_mem_stall,
  input  logic             flush,
  input  logic             dep_stall,
  input  logic             cnt_clr,
  output logic [2:0]       ex_dreg1,
  output logic [2:0]       ex_dreg2,
  output logic [2:0]       ex_dreg3,
  output logic [2:0]       ex_dmm,
  output logic [2:0]       ex_dseg,
  output logic             v_ex_ld_reg1,
  output logic             v_ex_ld_reg2,
  output logic             v_ex_ld_reg3,
  output logic             v_ex_ld_mm,
  output logic             v_ex_ld_seg,
  output logic [2:0]       wb_dreg1,
  output logic [2:0]       wb_dreg2,
  output logic [2:0]       wb_dreg3,
  output logic [2:0]       wb_dmm,
  output logic [2:0]       wb_dseg,
  output logic             v_wb_ld_reg1,
  output logic             v_wb_ld_reg2,
  output logic             v_wb_ld_reg3,
  output logic             v_wb_ld_mm,
  output logic             v_wb_ld_seg,
  output logic             V_wb,
  output logic [1:0]       inflight,
  output logic [CNT_W-1:0] dep_stall_cnt
);

  dest_bundle_t ro_bundle, ex_bundle_q, wb_bundle_q, ex_out, wb_out;
  stage_state_e ex_state, wb_state;
  logic         v_ex_q, v_wb_q;

  always_comb begin
    ro_bundle         = '0;
    ro_bundle.dreg1   = ro_dreg1;
    ro_bundle.dreg2   = ro_dreg2;
    ro_bundle.dreg3   = ro_dreg3;
    ro_bundle.ld_reg1 = v_ro_ld_reg1;
    ro_bundle.ld_reg2 = v_ro_ld_reg2;
    ro_bundle.ld_reg3 = v_ro_ld_reg3;
    ro_bundle.dmm     = ro_dmm;
    ro_bundle.ld_mm   = v_ro_ld_mm;
    ro_bundle.dseg    = ro_dseg;
    ro_bundle.ld_seg  = v_ro_ld_seg;
  end

  // Load-enable handshake: a stage captures its upstream whenever its enable is
  // high (EX: ld_ex, WB: !wb_mem_stall); there is no ready back-pressure here,
  // upstream derives ld_ex from the same stall inputs.
  ro_ex_wb_dest_pipe_stage u_ex_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (ld_ex),
    .valid_in  (V_ex),
    .bundle_in (ro_bundle),
    .state     (ex_state),
    .bundle_q  (ex_bundle_q)
  );

  // A stalled EX still shifts into WB, but as a bubble.
  ro_ex_wb_dest_pipe_stage u_wb_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (!wb_mem_stall),
    .valid_in  (v_ex_q & !ex_dep_stall),
    .bundle_in (ex_bundle_q),
    .state     (wb_state),
    .bundle_q  (wb_bundle_q)
  );

  assign v_ex_q = (ex_state == ST_OCCUPIED);
  assign v_wb_q = (wb_state == ST_OCCUPIED);
  assign ex_out = qualify(ex_bundle_q, v_ex_q);
  assign wb_out = qualify(wb_bundle_q, v_wb_q);

  assign ex_dreg1     = ex_out.dreg1;
  assign ex_dreg2     = ex_out.dreg2;
  assign ex_dreg3     = ex_out.dreg3;
  assign ex_dmm       = ex_out.dmm;
  assign ex_dseg      = ex_out.dseg;
  assign v_ex_ld_reg1 = ex_out.ld_reg1;
  assign v_ex_ld_reg2 = ex_out.ld_reg2;
  assign v_ex_ld_reg3 = ex_out.ld_reg3;
  assign v_ex_ld_mm   = ex_out.ld_mm;
  assign v_ex_ld_seg  = ex_out.ld_seg;

  assign wb_dreg1     = wb_out.dreg1;
  assign wb_dreg2     = wb_out.dreg2;
  assign wb_dreg3     = wb_out.dreg3;
  assign wb_dmm       = wb_out.dmm;
  assign wb_dseg      = wb_out.dseg;
  assign v_wb_ld_reg1 = wb_out.ld_reg1;
  assign v_wb_ld_reg2 = wb_out.ld_reg2;
  assign v_wb_ld_reg3 = wb_out.ld_reg3;
  assign v_wb_ld_mm   = wb_out.ld_mm;
  assign v_wb_ld_seg  = wb_out.ld_seg;

  assign V_wb     = v_wb_q;
  assign inflight = {1'b0, v_ex_q} + {1'b0, v_wb_q};

  // Performance counter: clear wins, saturates at all-ones, ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dep_stall_cnt <= '0;
    end else if (cnt_clr) begin
      dep_stall_cnt <= '0;
    end else if (dep_stall && (dep_stall_cnt != {CNT_W{1'b1}})) begin
      dep_stall_cnt <= dep_stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ro_ex_wb_dest_pipe.md
Name: ro_ex_wb_dest_pipe

Overview:
- Destination-tracking pipeline registers for the EX and WB stages, directly downstream of the read-operand (RO) stage.
- Captures each RO instruction's destination GPR, MMX and segment load-enables plus its valid bit.
- Advances them through EX then WB, and drives the qualified ex_* / wb_* destination buses back into the RO dependency-stall check.
- Also reports in-flight instruction count and a saturating dependency-stall performance counter.

Parameters:
CNT_W, 16, width of the dep_stall cycle counter (saturating)

Ports:
clk  in  1  stage clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_ex  in  1  EX latch enable from RO (= !(ex_dep_stall | wb_mem_stall))
V_ex  in  1  valid of the instruction leaving RO
ro_dreg1/ro_dreg2/ro_dreg3  in  3 each  GPR destination indices
v_ro_ld_reg1/v_ro_ld_reg2/v_ro_ld_reg3  in  1 each  GPR write enables (already V_ro-qualified)
ro_dmm  in  3  MMX destination index
v_ro_ld_mm  in  1  MMX write enable
ro_dseg  in  3  segment destination index
v_ro_ld_seg  in  1  segment write enable
ex_dep_stall  in  1  EX cannot complete this cycle
wb_mem_stall  in  1  WB stalled on memory
flush  in  1  pipeline kill (exception / redirect)
dep_stall  in  1  RO dependency stall, counted only
cnt_clr  in  1  synchronous clear of dep_stall_cnt
ex_dreg1/ex_dreg2/ex_dreg3, ex_dmm, ex_dseg  out  3 each  EX destination indices
v_ex_ld_reg1/v_ex_ld_reg2/v_ex_ld_reg3, v_ex_ld_mm, v_ex_ld_seg  out  1 each  EX enables, qualified by EX valid
wb_dreg1/wb_dreg2/wb_dreg3, wb_dmm, wb_dseg  out  3 each  WB destination indices
v_wb_ld_reg1/v_wb_ld_reg2/v_wb_ld_reg3, v_wb_ld_mm, v_wb_ld_seg  out  1 each  WB enables, qualified by WB valid
V_wb  out  1  WB stage valid
inflight  out  2  v_ex_q + v_wb_q (0..2)
dep_stall_cnt  out  CNT_W  saturating count of dep_stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): all registers and all outputs are 0. Includes valids, indices, enables, inflight and dep_stall_cnt.
- State is a two-stage valid pipeline. Per-stage states: EMPTY (valid=0) and OCCUPIED (valid=1).
- EX stage, in priority order:
  - flush=1: v_ex_q <= 0.
  - else ld_ex=1: v_ex_q <= V_ex; ex fields <= ro fields (raw enables).
  - else hold.
- WB stage, in priority order:
  - flush=1: v_wb_q <= 0.
  - else wb_mem_stall=0: v_wb_q <= v_ex_q & !ex_dep_stall; wb fields <= ex fields.
  - else hold.
  - ex_dep_stall=1 with wb_mem_stall=0 inserts a bubble into WB while EX holds.
- Field registers load on their stage enable regardless of valid. flush clears only the valids.
- Output qualification (combinational from flops):
  - v_ex_ld_* = ex_en_q & v_ex_q.
  - v_wb_ld_* = wb_en_q & v_wb_q.
  - V_wb = v_wb_q.
- Latency: one cycle RO->EX, one cycle EX->WB when unstalled. Same-cycle ld_ex and WB advance are a normal shift: WB takes the old EX contents.
- inflight: 2-bit sum of v_ex_q and v_wb_q, from flops.
- dep_stall_cnt:
  - cnt_clr=1 loads 0. cnt_clr has priority over increment.
  - else dep_stall=1 increments by 1, holding at 2^CNT_W-1.
  - Unaffected by flush.
- Boundary cases:
  - ld_ex=1 with V_ex=0 loads a bubble.
  - flush asserted during a stall still clears both valids next edge.
  - Reset asserted mid-operation clears immediately, without waiting for clk.

Decomposition:
- Shared package: REG_IDX_W=3, EAX=3'h0, ECX=3'h1, and a dest-bundle struct {dreg1..3, ld_reg1..3, dmm, ld_mm, dseg, ld_seg}.
- One natural sub-module: dest_stage_reg. It holds the valid bit plus the bundle, with load/flush/bubble control, and is instantiated once for EX and once for WB.

Test Plan:
- Reset then 1 instruction (ro_dreg1=3'h2, v_ro_ld_reg1=1, V_ex=1, ld_ex=1) -> next cycle ex_dreg1=2, v_ex_ld_reg1=1, inflight=1; following cycle v_wb_ld_reg1=1, V_wb=1, v_ex_ld_reg1=0.
- ex_dep_stall=1 for 2 cycles with EX occupied (ld_ex=0) -> EX outputs held, WB receives bubble (V_wb=0), inflight=1.
- wb_mem_stall=1 with both stages occupied -> EX and WB both hold all outputs for the stall duration, inflight=2.
- flush=1 with both occupied -> next edge V_wb=0, all v_ex_ld_*/v_wb_ld_* = 0, indices unchanged, inflight=0.
- CNT_W=4, dep_stall=1 for 20 cycles -> dep_stall_cnt=15 and stays; cnt_clr=1 concurrent with dep_stall=1 -> count=0.
- rst_n pulsed low between clock edges while occupied -> outputs 0 immediately, before the next rising clk.
